// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer with one-shot and auto-reload modes.
// Counts a loaded value down to zero, then pulses tc and either reloads or flags done.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Priority is reset > load > stop > start; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      count      <= load_value;
      reload_reg <= load_value;
      busy       <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tc <= 1'b0;
          if (start && !stop && (count != '0)) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            tc    <= 1'b0;
          end else if (count == '0) begin
            // The tc cycle: the only point where auto_reload matters.
            tc <= 1'b0;
            if (auto_reload && (reload_reg != '0)) begin
              count <= reload_reg;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            count <= count - 1'b1;
            tc    <= (count == WIDTH'(1));
          end
        end
        DONE: begin
          tc <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tc    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized and directed bench for down_counter_timer (WIDTH=8) against a
// behavioural timer model that tracks value, running and finished flags.
module tb_down_counter_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int total = 0;
  int bad = 0;

  // Model: remaining ticks, whether the timer is running, whether a one-shot finished.
  logic [W-1:0] mCount = '0;
  logic [W-1:0] mReload = '0;
  bit           mRun = 1'b0;
  bit           mFin = 1'b0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .count(count),
    .busy(busy),
    .tc(tc),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W+2:0] expv();
    return {mCount, mRun, mRun && (mCount == '0), mFin};
  endfunction

  task automatic modelEdge(input bit r, input bit l, input logic [W-1:0] lv,
                           input bit s, input bit p, input bit ar);
    if (r) begin
      mCount = '0; mReload = '0; mRun = 0; mFin = 0;
    end else if (l) begin
      mCount = lv; mReload = lv; mRun = 0; mFin = 0;
    end else if (mRun) begin
      if (p) mRun = 0;
      else if (mCount == 0) begin
        if (ar && mReload != 0) mCount = mReload;
        else begin mRun = 0; mFin = 1; end
      end else mCount = mCount - 1;
    end else if (!mFin && s && !p && mCount != 0) begin
      mRun = 1;
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [W-1:0] lv,
                      input bit s, input bit p, input bit ar);
    reset = r; load = l; load_value = lv; start = s; stop = p; auto_reload = ar;
    @(posedge clk);
    modelEdge(r, l, lv, s, p, ar);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    total++;
    if ({count, busy, tc, done} !== {W'(0), 3'b000}) begin
      bad++; $display("FAIL reset got=%h exp=%h", {count, busy, tc, done}, {W'(0), 3'b000});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0);
      total++;
      if ({count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL reset_start i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
    end
  endtask

  task automatic test_one_shot();
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      total++;
      if ({count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL oneshot i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
      if (i <= 5) begin
        total++;
        if (count !== W'(5 - i) || tc !== (i == 5)) begin
          bad++; $display("FAIL oneshot_seq i=%0d got cnt=%0d tc=%0b exp cnt=%0d tc=%0b", i, count, tc, 5 - i, i == 5);
        end
      end
      step(0, 0, 0, i == 7, 0, 0);
    end
    total++;
    if ({busy, tc, done} !== 3'b001) begin
      bad++; $display("FAIL oneshot_done got=%b exp=001", {busy, tc, done});
    end
  endtask

  task automatic test_periodic();
    int tcCount = 0;
    step(0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      total++;
      if ({count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL periodic i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
      if (tc) tcCount++;
      step(0, 0, 0, 0, 0, 1);
    end
    total++;
    if (tcCount != 3) begin
      bad++; $display("FAIL periodic_tc got=%0d exp=3", tcCount);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL periodic_end i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
    end
    total++;
    if (done !== 1'b1 || count !== '0) begin
      bad++; $display("FAIL periodic_done got done=%0b cnt=%0d exp done=1 cnt=0", done, count);
    end
  endtask

  task automatic test_pause_resume();
    step(0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (count !== W'(6) || busy !== 1'b0 || {count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL pause i=%0d got=%h exp cnt=6 busy=0", i, {count, busy, tc, done});
      end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({count, busy, tc, done} !== expv() || count !== W'(5 - i)) begin
        bad++; $display("FAIL resume i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    total++;
    if (busy !== 1'b0 || count !== W'(3)) begin
      bad++; $display("FAIL start_stop got busy=%0b cnt=%0d exp busy=0 cnt=3", busy, count);
    end
  endtask

  task automatic test_load_priority();
    step(0, 1, 15, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0, 0);
    total++;
    if ({count, busy, tc, done} !== {W'(2), 3'b000}) begin
      bad++; $display("FAIL load_prio got=%h exp=%h", {count, busy, tc, done}, {W'(2), 3'b000});
    end
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({count, busy, tc, done} !== expv()) begin
        bad++; $display("FAIL load_run i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step(0, 1, 200, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== W'(150)) begin
      bad++; $display("FAIL mid_run got cnt=%0d exp=150", count);
    end
    step(1, 0, 0, 1, 0, 1);
    total++;
    if ({count, busy, tc, done} !== {W'(0), 3'b000}) begin
      bad++; $display("FAIL reset_mid got=%h exp=%h", {count, busy, tc, done}, {W'(0), 3'b000});
    end
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    total++;
    if ({count, busy, tc, done} !== {W'(0), 3'b000}) begin
      bad++; $display("FAIL reset_idle got=%h exp=%h", {count, busy, tc, done}, {W'(0), 3'b000});
    end
  endtask

  task automatic test_random();
    bit ar = 0;
    for (int i = 0; i < 1500; i++) begin
      bit r = ($urandom_range(63) == 0);
      bit l = ($urandom_range(15) == 0);
      bit s = ($urandom_range(3) == 0);
      bit p = ($urandom_range(19) == 0);
      logic [W-1:0] lv = ($urandom_range(7) == 0) ? W'($urandom) : W'($urandom_range(6));
      if ($urandom_range(9) == 0) ar = ~ar;
      step(r, l, lv, s, p, ar);
      total++;
      if ({count, busy, tc, done} !== expv() || (tc && done)) begin
        bad++; $display("FAIL random i=%0d got=%h exp=%h", i, {count, busy, tc, done}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause_resume();
    test_load_priority();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Synchronous programmable down-counter/timer: the counting-down counterpart to the team's up ripple counter. Loads a start value, decrements once per clock while running, and flags terminal count (zero). Supports one-shot and auto-reload (periodic) modes. Used as a cycle timer/interval generator in counter lab designs alongside the up counter.

Parameters:
WIDTH, 4, bit width of count, load_value and internal reload register.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  load strobe; captures load_value.
load_value  input  WIDTH  value for count and reload register.
start  input  1  begin/resume counting.
stop  input  1  pause counting.
auto_reload  input  1  1 = periodic mode, 0 = one-shot.
count  output  WIDTH  current counter value (registered).
busy  output  1  high while in RUN.
tc  output  1  terminal-count pulse (registered).
done  output  1  one-shot completion flag (registered level).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Internal: state {IDLE, RUN, DONE}; reload_reg[WIDTH-1:0].
- Reset (at a clk edge with reset=1, any state, including mid-RUN): state=IDLE, count=0, reload_reg=0, busy=0, tc=0, done=0. Reset overrides all other inputs.
- Input priority per cycle: reset > load > stop > start.
- load=1: count<=load_value, reload_reg<=load_value, state<=IDLE, done<=0, tc<=0. Applies in any state; aborts RUN.
- IDLE: start=1 and stop=0 and count!=0 -> RUN. start with count==0 ignored (stay IDLE). count holds.
- RUN: each cycle count<=count-1.
  - When count==1 at an edge: count<=0, tc<=1 (tc high exactly the one cycle count==0).
  - While count==0 in RUN (the tc cycle): if auto_reload=1 and reload_reg!=0 -> count<=reload_reg, stay RUN, tc<=0. Else -> state<=DONE, done<=1, count stays 0, tc<=0.
  - auto_reload sampled only in the tc cycle; may change at any other time without effect.
  - stop=1 -> IDLE, count holds current value (no decrement that cycle); tc<=0. A later start resumes from held value.
  - start while RUN: no effect.
- DONE: count=0, done=1 held until load or reset. start ignored (count==0). stop ignored.
- Timing: start sampled at edge k enters RUN; first decrement at edge k+1. Load N (N>=1), start: count N,N-1,...,1,0 over N cycles after entering RUN; tc on the 0 cycle; done rises next edge. Periodic period = N+1 cycles (N..0).
- No wrap-around below zero: count never decrements from 0 (0 -> reload or DONE).
- busy = (state==RUN), registered with state. tc never asserted outside RUN; tc and done never high in same cycle.
- Arithmetic: unsigned, modulo-free; full range 1..2^WIDTH-1 valid load values; load 0 gives no-op run.

Test Plan:
- Reset then idle: reset=1 two cycles, release -> count=0, busy=0, tc=0, done=0; start alone -> stays IDLE, count=0.
- One-shot: load_value=5, load, start, auto_reload=0 -> count 5,4,3,2,1,0; tc=1 only in the count=0 cycle; done=1 next cycle and held; busy falls with done; start ignored afterwards.
- Periodic: load 3, auto_reload=1, start -> count 3,2,1,0,3,2,1,0,...; tc pulses every 4 cycles; done stays 0; clear auto_reload before a 0 cycle -> ends in DONE.
- Pause/resume: load 10, start, stop when count=6 -> count holds 6, busy=0 for 4 cycles; start -> resumes 5,4...; start+stop same cycle -> stays stopped.
- Load mid-run/priority: load 15, start, at count=12 assert load with load_value=2 and start together -> count=2, state IDLE, done=0; next start runs 2,1,0 then DONE.
- Reset mid-operation and WIDTH=8: load 200, start, reset at count=150 -> next cycle all outputs 0, reload_reg=0; start with no load stays IDLE.
